// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - GF(2^5) field constants, RS(18,16) generator and shared types
package rs_pkg;

  localparam int SYMBOL_WIDTH = 5;
  localparam int K            = 16;
  localparam int N            = 18;

  typedef logic [SYMBOL_WIDTH-1:0] symbol_t;

  // Field: x^5 + x^2 + 1, alpha = x
  localparam symbol_t PRIM_POLY = 5'b00101;
  localparam symbol_t ALPHA     = 5'b00010;
  localparam symbol_t ALPHA2    = 5'b00100;

  // g(x) = (x + alpha)(x + alpha^2) = x^2 + G1*x + G0
  localparam symbol_t G1 = 5'b00110;
  localparam symbol_t G0 = 5'b01000;

  typedef enum logic [1:0] {
    DATA = 2'd0,
    PAR1 = 2'd1,
    PAR0 = 2'd2
  } enc_state_t;

  // Shift-and-add multiply; with a constant operand this folds to an XOR network
  function automatic symbol_t gf_mul(input symbol_t a, input symbol_t b);
    symbol_t p;
    symbol_t x;
    p = '0;
    x = a;
    for (int i = 0; i < SYMBOL_WIDTH; i++) begin
      if (b[i]) p = p ^ x;
      x = x[SYMBOL_WIDTH-1] ? ((x << 1) ^ PRIM_POLY) : (x << 1);
    end
    return p;
  endfunction

endpackage

// File: rtl/rs_stream_encoder_if.sv
// rtl/rs_stream_encoder_if.sv - input/output symbol streams of the RS encoder
interface rs_stream_encoder_if;
  import rs_pkg::*;

  logic    in_valid;
  logic    in_ready;
  symbol_t in_data;
  logic    in_last;
  logic    out_valid;
  logic    out_ready;
  symbol_t out_data;
  logic    out_last;
  logic    frame_err;

  // Encoder side
  modport master (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, frame_err
  );

  // Environment side (producer of data, consumer of codewords)
  modport slave (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, frame_err
  );

endinterface

// File: rtl/rs_parity_lfsr.sv
// rtl/rs_parity_lfsr.sv - two-stage GF(2^5) division LFSR holding the parity remainder
module rs_parity_lfsr
  import rs_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clear,
  input  logic    shift_en,
  input  symbol_t din,
  output symbol_t r1,
  output symbol_t r0
);

  symbol_t fb;

  assign fb = din ^ r1;

  // Divide by g(x); clear wins so the next codeword starts from a zero remainder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1 <= '0;
      r0 <= '0;
    end else if (clear) begin
      r1 <= '0;
      r0 <= '0;
    end else if (shift_en) begin
      r1 <= r0 ^ gf_mul(G1, fb);
      r0 <= gf_mul(G0, fb);
    end
  end

endmodule

// File: rtl/rs_stream_encoder.sv
// rtl/rs_stream_encoder.sv - streaming systematic RS(18,16) encoder over GF(2^5)
module rs_stream_encoder (
  input  logic             clk,
  input  logic             rst_n,
  rs_stream_encoder_if.master bus
);
  import rs_pkg::*;

  localparam int CNT_W = $clog2(K);

  enc_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic    out_valid_q, out_last_q, frame_err_q;
  symbol_t out_data_q;

  logic    slot_free, in_ready_c, accept;
  logic    load, load_last, err_d;
  symbol_t load_data;
  logic    lfsr_shift, lfsr_clear;
  symbol_t r1, r0;

  assign slot_free = !out_valid_q || bus.out_ready;

  rs_parity_lfsr u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (lfsr_clear),
    .shift_en (lfsr_shift),
    .din      (bus.in_data),
    .r1       (r1),
    .r0       (r0)
  );

  // State and symbol count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DATA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, output-slot load selection and in_last framing check
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_ready_c = 1'b0;
    accept     = 1'b0;
    load       = 1'b0;
    load_data  = out_data_q;
    load_last  = 1'b0;
    lfsr_shift = 1'b0;
    lfsr_clear = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      DATA: begin
        in_ready_c = slot_free;
        accept     = bus.in_valid && in_ready_c;
        if (accept) begin
          load       = 1'b1;
          load_data  = bus.in_data;
          lfsr_shift = 1'b1;
          if (cnt_q == CNT_W'(K - 1)) begin
            cnt_d   = '0;
            state_d = PAR1;
            err_d   = !bus.in_last;
          end else begin
            cnt_d = cnt_q + 1'b1;
            err_d = bus.in_last;
          end
        end
      end
      PAR1: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = r1;
          state_d   = PAR0;
        end
      end
      PAR0: begin
        if (slot_free) begin
          load       = 1'b1;
          load_data  = r0;
          load_last  = 1'b1;
          lfsr_clear = 1'b1;
          state_d    = DATA;
        end
      end
      default: state_d = DATA;
    endcase
  end

  // Single output register stage; holds while stalled, drains when consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= err_d;
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= load_data;
        out_last_q  <= load_last;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: doc/rs_stream_encoder.md
Name: rs_stream_encoder

Overview:
- Streaming systematic RS(18,16) encoder over GF(2^5).
- Transmit-side counterpart of the single-error-correcting RS decoder: its codewords have zero syndromes at alpha^1 and alpha^2, so the decoder's S1/S2 computation returns 0/0 on error-free output.
- Accepts 16 data symbols one per beat over a valid/ready stream.
- Forwards the data symbols unchanged, then appends 2 parity symbols computed by a 2-stage GF LFSR.

Parameters:
- SYMBOL_WIDTH, 5, bits per symbol.
- K, 16, data symbols per codeword.
- N, 18, total symbols per codeword (N-K = 2 parity symbols, fixed by the LFSR depth).
- PRIM_POLY, 5'b00101, low bits of primitive polynomial x^5+x^2+1; alpha = 5'b00010.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, data symbol offered.
- in_ready, output, 1, encoder accepts the symbol this cycle.
- in_data, input, SYMBOL_WIDTH, data symbol; first symbol = highest-degree coefficient (codeword index N-1).
- in_last, input, 1, sender's end-of-message marker; checked only.
- out_valid, output, 1, output symbol valid.
- out_ready, input, 1, downstream accepts.
- out_data, output, SYMBOL_WIDTH, codeword symbol, index N-1 down to 0.
- out_last, output, 1, high with the final parity symbol (index 0).
- frame_err, output, 1, one-cycle pulse on an in_last mismatch.

Behaviour:
- Interface and reset:
  - One clock, clk. Reset rst_n is asynchronous, active-low.
  - Reset values: out_valid=0, out_data=0, out_last=0, frame_err=0, LFSR r1=r0=0, state DATA, symbol count 0.
- Generator:
  - g(x) = (x+alpha)(x+alpha^2) = x^2 + g1*x + g0.
  - g1 = 5'b00110, g0 = 5'b01000.
- Output register: a single register stage. It may load when out_valid==0 or out_ready==1 ("slot free").
- DATA state:
  - in_ready = slot free.
  - An accepted beat (in_valid & in_ready) does three things:
    - out_data <= in_data, out_valid <= 1, out_last <= 0.
    - f = in_data ^ r1.
    - r1 <= r0 ^ gf_mul(g1,f) and r0 <= gf_mul(g0,f).
  - The count increments on each accepted beat. On the K-th beat the count resets to 0 and the state goes to PAR1.
- PAR1 state:
  - in_ready = 0.
  - When the slot is free: out_data <= r1, out_valid <= 1, out_last <= 0, then go to PAR0.
- PAR0 state:
  - in_ready = 0.
  - When the slot is free: out_data <= r0, out_last <= 1.
  - In the same cycle: clear r1 and r0, go to DATA.
- Output draining:
  - If out_ready=1 with nothing new loaded, out_valid <= 0.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
- Latency and throughput:
  - Accepted symbol appears on out_data the next cycle.
  - With out_ready held high: 18 output beats per 16 input beats, 2 bubble cycles on the input per codeword.
- in_last checking:
  - frame_err pulses for one cycle in two cases: an accepted beat with in_last=1 whose count != K-1, or the K-th accepted beat with in_last=0.
  - The encoder never resynchronises on in_last; framing is by count only.
- Other rules:
  - in_valid while in_ready=0 is ignored; no state change.
  - The last data symbol accepted and the first parity symbol loading can never coincide, since PAR1 is entered only after the K-th beat.
  - rst_n assertion mid-codeword discards the partial codeword immediately. Output goes to out_valid=0 asynchronously. No parity is emitted.
- Arithmetic: gf_mul is combinational constant-operand GF(2^5) multiplication mod PRIM_POLY, result SYMBOL_WIDTH bits.

Decomposition:
- Shared package rs_pkg holds:
  - SYMBOL_WIDTH, K, N, PRIM_POLY, G1, G0.
  - typedef symbol_t (logic [SYMBOL_WIDTH-1:0]).
  - enum enc_state_t {DATA, PAR1, PAR0}.
  - function gf_mul.
- The decoder's field constants move into the same package.
- One natural sub-module: rs_parity_lfsr. It holds r1/r0 with inputs clear, shift_en, din and outputs r1, r0.
- FSM and handshake stay in the top module.

Test Plan:
1. All-zero message, out_ready=1, in_valid=1 continuously -> 18 beats of 0, out_last on beat 18, in_ready low 2 cycles, frame_err never pulses.
2. Message 15 zeros then 5'd1 (in_last on 16th) -> data echoed, parity 5'd6 then 5'd8, out_last with 5'd8.
3. Random messages, random in_valid and out_ready (30% stall) -> output matches reference model. Captured codeword fed to the existing decoder gives corrected == codeword and S1=S2=0. out_data stays stable during stalls.
4. in_last asserted on beat 10 -> frame_err pulses the cycle after that beat. Also in_last absent on beat 16 -> frame_err pulses. Parity still emitted after beat 16 in both cases.
5. rst_n pulled low after 7 accepted symbols -> out_valid=0 immediately. Next message encodes as in scenario 2 (6, 8) with no carry-over.
6. out_ready held low during PAR0 for 5 cycles -> out_data=5'd8 and out_last=1 held, in_ready=0, next data accepted the cycle out_ready rises.
